// File: rtl/capture_arbiter_pkg.sv
// Shared types and helpers for the capture_arbiter round-robin capture scheduler.
// Optional build macro used by the top level: CAPTURE_ARBITER_PRIORITY_EN.
package capture_arbiter_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } state_t;

   // Index width for n items, never narrower than one bit.
   function automatic int tag_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Pointer value after reset: the last requester, so requester 0 wins first.
   function automatic int rst_ptr(input int n);
      return n - 1;
   endfunction

endpackage

// File: rtl/capture_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req strictly after ptr, wrapping.
module capture_arbiter_rr_pick
   import capture_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]          req,
   input  logic [tag_w(NUM_REQ)-1:0]   ptr,
   output logic [NUM_REQ-1:0]          win_oh,
   output logic [tag_w(NUM_REQ)-1:0]   win_idx,
   output logic                        any
);

   localparam int TW = tag_w(NUM_REQ);

   logic          found;
   int            pos;
   logic [TW-1:0] pos_t;

   assign any = |req;

   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      found   = 1'b0;
      pos     = 0;
      pos_t   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         pos   = (int'(ptr) + k) % NUM_REQ;
         pos_t = TW'(pos);
         if (!found && req[pos_t]) begin
            found          = 1'b1;
            win_idx        = pos_t;
            win_oh[pos_t]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/capture_arbiter.sv
// Round-robin owner of a shared SYNC_STAGES-deep capture chain; emits data plus requester tag.
// Build macro CAPTURE_ARBITER_PRIORITY_EN makes requester 0 win whenever it requests in IDLE.
module capture_arbiter
   import capture_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          gnt,
   output logic                        busy,
   output logic                        out_valid,
   output logic [DATA_W-1:0]           out_data,
   output logic [tag_w(NUM_REQ)-1:0]   out_tag
);

   localparam int TW = tag_w(NUM_REQ);
   localparam int CW = tag_w(SYNC_STAGES);
   localparam logic [TW-1:0] PTR_RST  = TW'(rst_ptr(NUM_REQ));
   localparam logic [CW-1:0] CNT_LOAD = CW'(SYNC_STAGES - 1);

   state_t             state, state_nxt;
   logic [TW-1:0]      ptr, tag;
   logic [TW-1:0]      rr_idx, win_idx;
   logic [NUM_REQ-1:0] rr_oh, win_oh;
   logic               rr_any;
   logic [CW-1:0]      cnt;
   logic [DATA_W-1:0]  stage [SYNC_STAGES];
   logic               load, done;

   capture_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req     (req),
      .ptr     (ptr),
      .win_oh  (rr_oh),
      .win_idx (rr_idx),
      .any     (rr_any)
   );

   always_comb begin
      win_oh  = rr_oh;
      win_idx = rr_idx;
`ifdef CAPTURE_ARBITER_PRIORITY_EN
      if (req[0]) begin
         win_oh  = NUM_REQ'(1);
         win_idx = '0;
      end
`endif
   end

   // Handshake: req is a level held until gnt; gnt is a one-cycle pulse in the
   // cycle after the grant edge, and req is only sampled while state is IDLE.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (rr_any) begin
               load      = 1'b1;
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == '0) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
         tag       <= '0;
         ptr       <= PTR_RST;
         cnt       <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
      end else begin
         gnt       <= '0;
         out_valid <= 1'b0;
         if (load) begin
            stage[0] <= req_data[int'(win_idx)*DATA_W +: DATA_W];
            tag      <= win_idx;
            gnt      <= win_oh;
            ptr      <= win_idx;
            cnt      <= CNT_LOAD;
         end else if (state == SETTLE) begin
            for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
            // The output register samples the chain tail before this edge's shift lands.
            if (done) begin
               out_data  <= stage[SYNC_STAGES-1];
               out_tag   <= tag;
               out_valid <= 1'b1;
            end else begin
               cnt <= cnt - CW'(1);
            end
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/capture_arbiter.md
# capture_arbiter

Round-robin scheduler that shares a single multi-stage capture/synchronizer register chain among `NUM_REQ` requesters inside the timing-benchmark netlists. It grants one requester at a time, loads that requester's data into the shared chain and sequences it through `SYNC_STAGES` registers. It then presents the result with a requester tag, giving timing tools a multi-path, FSM-controlled capture structure to constrain.

## Interface
- `NUM_REQ`, 4: number of requesters, at least 2.
- `DATA_W`, 8: data width per requester.
- `SYNC_STAGES`, 2: depth of the shared register chain, at least 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in `NUM_REQ`: per-requester level request, held until granted.
- `req_data` in `NUM_REQ*DATA_W`: requester i occupies bits [i*DATA_W +: DATA_W].
- `gnt` out `NUM_REQ`: registered one-hot grant, one-cycle pulse.
- `busy` out 1: high while a transaction occupies the chain (state != IDLE).
- `out_valid` out 1: one-cycle pulse when `out_data`/`out_tag` are valid.
- `out_data` out `DATA_W`: captured data after the chain.
- `out_tag` out `$clog2(NUM_REQ)`: index of the requester that owns `out_data`.

## Operation
- Two-state FSM: IDLE and SETTLE.
- IDLE with `req` nonzero at edge E0:
  - pick the winner;
  - stage[0] <= winner's `req_data`;
  - tag <= winner;
  - `gnt` <= onehot(winner);
  - pointer <= winner;
  - cnt <= `SYNC_STAGES`-1;
  - state <= SETTLE.
- IDLE with `req` == 0: no change, `gnt` = 0.
- SETTLE, each edge:
  - stage[i] <= stage[i-1] for i > 0;
  - when cnt == 0: `out_data` <= stage[`SYNC_STAGES`-1], `out_tag` <= tag, `out_valid` <= 1, state <= IDLE;
  - otherwise cnt decrements.
- With `SYNC_STAGES` == 1, SETTLE lasts exactly one edge.
- Winner selection: first asserted `req` searching from pointer+1 upward, wrapping modulo `NUM_REQ`.
- `req` and `req_data` are ignored outside IDLE. A requester must drop `req` in the cycle `gnt` is high; a `req` still high when IDLE is re-entered is treated as a new request.
- Changes to `req_data` after the grant edge do not affect `out_data`.
- `out_data` and `out_tag` hold their value between `out_valid` pulses.
- Reset values:
  - `gnt`=0, `busy`=0, `out_valid`=0, `out_data`=0, `out_tag`=0;
  - stages=0, cnt=0, state=IDLE;
  - pointer=`NUM_REQ`-1, so requester 0 has first priority after reset.
- Reset mid-transaction discards the in-flight data. No `out_valid` is produced for it.

## Timing
- `gnt` is high in the cycle after E0.
- `busy` rises together with `gnt`.
- `out_valid` is high in the cycle after edge E0+`SYNC_STAGES`.
- `busy` falls at that same edge.
- The earliest next grant edge is E0+`SYNC_STAGES`+1, so the maximum rate is one transaction per `SYNC_STAGES`+1 cycles.
- `out_valid` and the next `gnt` are never high in the same cycle.
- `rst` clears all state and outputs asynchronously. The first grant after deassertion occurs at the first edge with `rst` low and `req` nonzero.

## Configuration
- `CAPTURE_ARBITER_PRIORITY_EN` defined: requester 0 is high priority and wins whenever `req[0]` is set in IDLE.
  - The pointer is still updated to the winner.
  - Remaining requesters stay round-robin among themselves.
- Not defined: pure round-robin for all requesters, as described above.

## Structure
- Package `capture_arbiter_pkg` holds:
  - the state enum (IDLE, SETTLE);
  - the tag-width helper function;
  - the reset pointer constant.
- Sub-module `capture_arbiter_rr_pick`: combinational round-robin picker.
  - Inputs: `req` and the pointer.
  - Outputs: a one-hot winner, its index and an any-request flag.
- The priority macro is applied in the top level around the picker output.

## Test plan
All scenarios use `NUM_REQ`=4, `DATA_W`=8, `SYNC_STAGES`=2.
- Assert `rst` mid-run, then release with `req`=0 → all outputs 0, `busy`=0, no `gnt`.
- `req`=4'b0100, data2=0xA5, held until `gnt` → `gnt`=4'b0100 for one cycle; two cycles later `out_valid`=1, `out_data`=0xA5, `out_tag`=2.
- `req`=4'b1111 held continuously, data i=0x10+i → tags 0,1,2,3,0 with data 0x10..0x13,0x10; `out_valid` every 3 cycles.
- Change data2 to 0xFF one cycle after its grant; pulse `req[1]` during SETTLE → `out_data`=0xA5; `req[1]` gets no grant.
- Assert `rst` during SETTLE → `busy` drops immediately; no `out_valid`; after release, `req`=4'b1001 grants requester 0 first.
- `req`=4'b1001 held continuously → grants 0,0,0 with `CAPTURE_ARBITER_PRIORITY_EN`; 0,3,0,3 without.
